move_sequence_decoder: RTL and testbench

Consumes the single-cycle debounced press pulses from the per-button debouncers and turns them into fighter move events. Sits between the input debouncers and the fighter state logic. Keeps a short history of direction presses, expires it after a timeout, and on each punch press emits one registered move event: plain punch, fireball or uppercut.

---
 rtl/move_sequence_decoder.sv | 154 +++++++++++++++
 tb/tb_move_sequence_decoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/move_sequence_decoder.sv
// move_sequence_decoder
// Turns debounced direction/punch press pulses into fighter move events.
// Keeps a 3-deep history of direction tokens. The history expires after
// WINDOW idle cycles. Each punch produces one registered PUNCH, FIREBALL
// or UPPERCUT event.
// Optional feature macro: MOVE_SEQUENCE_DECODER_UPPERCUT_EN. When it is
// defined, the decoder recognises FWD, DOWN, FWD, PUNCH as an UPPERCUT.
module move_sequence_decoder #(
  parameter int unsigned WINDOW = 20_000_000,
  parameter int unsigned WIN_W  = 25
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DPB_UP,
  input  logic       DPB_DOWN,
  input  logic       DPB_LEFT,
  input  logic       DPB_RIGHT,
  input  logic       DPB_PUNCH,
  input  logic       FACING,
  output logic       MOVE_VALID,
  output logic [1:0] MOVE_CODE
);

  typedef enum logic [1:0] {
    TOK_DOWN = 2'b00,
    TOK_FWD  = 2'b01,
    TOK_BACK = 2'b10,
    TOK_UP   = 2'b11
  } tok_t;

  typedef enum logic [1:0] {
    MV_NONE     = 2'b00,
    MV_PUNCH    = 2'b01,
    MV_FIREBALL = 2'b10,
    MV_UPPERCUT = 2'b11
  } move_t;

  // Expiry fires on the edge that closes cycle t+WINDOW. At that point GAP
  // still reads WINDOW-1, so a press in that same cycle still sees the history.
  localparam logic [WIN_W-1:0] GAP_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] GAP_MAX  = WIN_W'(WINDOW);
  localparam logic [WIN_W-1:0] GAP_ONE  = WIN_W'(1);

  tok_t             h0, h1, h2;
  logic [1:0]       hcnt;
  logic [WIN_W-1:0] gap;

  tok_t             h0_n, h1_n, h2_n;
  logic [1:0]       hcnt_n;
  logic [WIN_W-1:0] gap_n;

  logic             tok_valid;
  tok_t             tok;
  logic             fwd_btn, back_btn;

  logic [1:0]       eval_cnt;
  logic             fb_hit, uc_hit;
  move_t            move_n;

  // Form at most one direction token per cycle: DOWN > FWD > BACK > UP
  always_comb begin
    fwd_btn   = FACING ? DPB_RIGHT : DPB_LEFT;
    back_btn  = FACING ? DPB_LEFT  : DPB_RIGHT;
    tok_valid = 1'b1;
    tok       = TOK_DOWN;
    if (DPB_DOWN) begin
      tok = TOK_DOWN;
    end else if (fwd_btn) begin
      tok = TOK_FWD;
    end else if (back_btn) begin
      tok = TOK_BACK;
    end else if (DPB_UP) begin
      tok = TOK_UP;
    end else begin
      tok_valid = 1'b0;
    end
  end

  // Next history/gap state and punch classification against the updated history
  always_comb begin
    h0_n     = h0;
    h1_n     = h1;
    h2_n     = h2;
    hcnt_n   = hcnt;
    gap_n    = gap;
    eval_cnt = hcnt;

    if (tok_valid) begin
      h0_n     = tok;
      h1_n     = h0;
      h2_n     = h1;
      hcnt_n   = (hcnt == 2'd3) ? 2'd3 : hcnt + 2'd1;
      eval_cnt = hcnt_n;
      gap_n    = '0;
    end else if (hcnt != 2'd0) begin
      if (gap == GAP_LAST) begin
        hcnt_n = 2'd0;
      end
      gap_n = (gap == GAP_MAX) ? gap : gap + GAP_ONE;
    end

    // The same-cycle token has already been appended. Expiry on this edge
    // must not hide the history from a punch arriving in the final cycle,
    // so the evaluation uses eval_cnt rather than hcnt_n.
    fb_hit = (eval_cnt >= 2'd2) && (h0_n == TOK_FWD) && (h1_n == TOK_DOWN);
`ifdef MOVE_SEQUENCE_DECODER_UPPERCUT_EN
    uc_hit = (eval_cnt == 2'd3) && fb_hit && (h2_n == TOK_FWD);
`else
    uc_hit = 1'b0;
`endif

    if (uc_hit) begin
      move_n = MV_UPPERCUT;
    end else if (fb_hit) begin
      move_n = MV_FIREBALL;
    end else begin
      move_n = MV_PUNCH;
    end

    if (DPB_PUNCH) begin
      hcnt_n = 2'd0;
      gap_n  = '0;
    end
  end

  // History, fill count and gap counter registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      h0   <= TOK_DOWN;
      h1   <= TOK_DOWN;
      h2   <= TOK_DOWN;
      hcnt <= 2'd0;
      gap  <= '0;
    end else begin
      h0   <= h0_n;
      h1   <= h1_n;
      h2   <= h2_n;
      hcnt <= hcnt_n;
      gap  <= gap_n;
    end
  end

  // Registered one-cycle move event; the code reads 00 whenever no event is present
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      MOVE_VALID <= 1'b0;
      MOVE_CODE  <= MV_NONE;
    end else begin
      MOVE_VALID <= DPB_PUNCH;
      MOVE_CODE  <= DPB_PUNCH ? move_n : MV_NONE;
    end
  end

endmodule

// File: tb/tb_move_sequence_decoder.sv
// Directed bench for move_sequence_decoder with WINDOW = 8.
// Inputs are driven on the falling edge and outputs are sampled on the following falling edge.
module tb_move_sequence_decoder;

  localparam int unsigned WINDOW = 8;
  localparam int unsigned WIN_W  = 4;

  // Button vector layout: {UP, DOWN, LEFT, RIGHT, PUNCH}
  localparam logic [4:0] B_UP = 5'b10000;
  localparam logic [4:0] B_DN = 5'b01000;
  localparam logic [4:0] B_L  = 5'b00100;
  localparam logic [4:0] B_R  = 5'b00010;
  localparam logic [4:0] B_P  = 5'b00001;
  localparam logic [4:0] B_ALL = 5'b11111;

`ifdef MOVE_SEQUENCE_DECODER_UPPERCUT_EN
  localparam logic [1:0] UC_EXP = 2'b11;
`else
  localparam logic [1:0] UC_EXP = 2'b10;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       DPB_UP = 1'b0, DPB_DOWN = 1'b0, DPB_LEFT = 1'b0;
  logic       DPB_RIGHT = 1'b0, DPB_PUNCH = 1'b0;
  logic       FACING = 1'b1;
  logic       MOVE_VALID;
  logic [1:0] MOVE_CODE;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  move_sequence_decoder #(.WINDOW(WINDOW), .WIN_W(WIN_W)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DPB_UP     (DPB_UP),
    .DPB_DOWN   (DPB_DOWN),
    .DPB_LEFT   (DPB_LEFT),
    .DPB_RIGHT  (DPB_RIGHT),
    .DPB_PUNCH  (DPB_PUNCH),
    .FACING     (FACING),
    .MOVE_VALID (MOVE_VALID),
    .MOVE_CODE  (MOVE_CODE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one cycle of buttons (called at a falling edge) and return at the next falling edge
  task automatic step(input logic [4:0] b);
    {DPB_UP, DPB_DOWN, DPB_LEFT, DPB_RIGHT, DPB_PUNCH} = b;
    @(negedge CLK);
    {DPB_UP, DPB_DOWN, DPB_LEFT, DPB_RIGHT, DPB_PUNCH} = '0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step('0);
  endtask

  // Issue a punch (plus optional same-cycle direction) and check the resulting event
  task automatic punch(input string tag, input logic [4:0] extra, input logic [1:0] exp_code);
    step(extra | B_P);
    check({tag, ".valid"}, {7'd0, MOVE_VALID}, 8'd1);
    check({tag, ".code"},  {6'd0, MOVE_CODE},  {6'd0, exp_code});
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, ".valid"}, {7'd0, MOVE_VALID}, 8'd0);
    check({tag, ".code"},  {6'd0, MOVE_CODE},  8'd0);
  endtask

  initial begin
    @(negedge CLK);
    // Reset held: every input pulsed, no event ever appears
    expect_quiet("rst0");
    step(B_ALL);             expect_quiet("rst_all");
    step(B_DN);              expect_quiet("rst_dn");
    step(B_R | B_P);         expect_quiet("rst_rp");
    step(B_P);               expect_quiet("rst_p");
    RESET = 1'b1;
    idle(1);
    punch("post_rst", '0, 2'b01);
    step('0);                expect_quiet("post_rst_drop");

    // Fireball at the window edge: k = 8 still counts
    step(B_DN); idle(2); step(B_R); idle(7);
    punch("fb_k8", '0, 2'b10);
    step('0);                expect_quiet("fb_k8_drop");

    // k = 9: history already expired
    step(B_DN); idle(2); step(B_R); idle(8);
    punch("fb_k9", '0, 2'b01);

    // Token arriving at k = 9 lands in an emptied history
    step(B_DN); idle(8); step(B_R);
    punch("tok_k9", '0, 2'b01);

    // Uppercut at 2-cycle spacing
    step(B_R); idle(1); step(B_DN); idle(1); step(B_R); idle(1);
    punch("uppercut", '0, UC_EXP);
    step('0);                expect_quiet("uc_drop");

    // Facing left: LEFT is forward
    FACING = 1'b0;
    step(B_DN); step(B_L);
    punch("face_l_fwd", '0, 2'b10);
    step(B_DN); step(B_R);
    punch("face_l_back", '0, 2'b01);
    FACING = 1'b1;

    // Stored tokens keep their entry-time meaning
    step(B_DN); step(B_R);
    FACING = 1'b0;
    punch("face_stale", '0, 2'b10);
    FACING = 1'b1;

    // UP breaks a combo
    step(B_DN); step(B_R); step(B_UP);
    punch("up_break", '0, 2'b01);

    // Direction and punch in the same cycle
    step(B_DN);
    punch("same_cyc", B_R, 2'b10);

    // DOWN wins over RIGHT
    step(B_DN | B_R);
    punch("prio", '0, 2'b01);

    // Back-to-back punches after a fireball sequence
    step(B_DN); step(B_R);
    punch("b2b_1", '0, 2'b10);
    punch("b2b_2", '0, 2'b01);
    step('0);                expect_quiet("b2b_drop");

    // Reset mid-combo discards history
    step(B_DN); step(B_R);
    RESET = 1'b0;
    #1;                      expect_quiet("rst_mid_async");
    step(B_P);               expect_quiet("rst_mid_punch");
    RESET = 1'b1;
    idle(1);
    punch("rst_mid", '0, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
